// File: rtl/tft_fb_arbiter.sv
// Framebuffer RAM arbiter: display scan-out reads always win the single RAM port,
// the drawing writer is granted only in slots where no scan-out pixel is requested.
module tft_fb_arbiter #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480,
    parameter int DATA_W   = 24,
    parameter int ADDR_W   = 19,
    parameter int RD_LAT   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              vs,
    input  logic              pix_req,
    input  logic [9:0]        pix_x,
    input  logic [8:0]        pix_y,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    output logic              frame_start,
    output logic              err_oob,
    output logic [15:0]       stall_cnt
);

    localparam logic [9:0]        H_LIM       = 10'(H_ACTIVE);
    localparam logic [8:0]        V_LIM       = 9'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] H_STRIDE    = ADDR_W'(H_ACTIVE);
    localparam logic [ADDR_W:0]   PIX_TOTAL_C = (ADDR_W + 1)'(H_ACTIVE * V_ACTIVE);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_n_s;
    logic                vs_d_r;
    logic [RD_LAT:0]     vld_pipe_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic                mem_we_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic                frame_start_r;
    logic                err_oob_r;
    logic [15:0]         stall_cnt_r;

    logic                vs_fall_s;
    logic                run_blk_s;
    logic                rd_issue_s;
    logic                wr_ready_s;
    logic                wr_acc_s;
    logic                wr_inb_s;
    logic [ADDR_W-1:0]   rd_lin_s;

    // Slot ownership and address decode for the current cycle.
    assign vs_fall_s  = vs_d_r & ~vs;
    assign run_blk_s  = (state_r == ST_RUN) & pix_req;
    assign rd_issue_s = run_blk_s & (pix_x < H_LIM) & (pix_y < V_LIM);
    assign wr_ready_s = ~run_blk_s;
    assign wr_acc_s   = wr_valid & wr_ready_s;
    assign wr_inb_s   = ({1'b0, wr_addr} < PIX_TOTAL_C);
    // The operands are widened to the full address width before the multiply.
    assign rd_lin_s   = (ADDR_W'(pix_y) * H_STRIDE) + ADDR_W'(pix_x);

    // Scan-out enable / vsync alignment next-state logic.
    always_comb begin
        state_n_s = state_r;
        if (!enable) begin
            state_n_s = ST_OFF;
        end else begin
            case (state_r)
                ST_OFF:  state_n_s = ST_WAIT;
                ST_WAIT: begin
                    if (vs_fall_s) begin
                        state_n_s = ST_RUN;
                    end else begin
                        state_n_s = ST_WAIT;
                    end
                end
                ST_RUN:  state_n_s = ST_RUN;
                default: state_n_s = ST_OFF;
            endcase
        end
    end

    // State, vsync history and read-valid pipeline registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_OFF;
            vs_d_r     <= 1'b1;
            vld_pipe_r <= '0;
        end else begin
            state_r    <= state_n_s;
            vs_d_r     <= vs;
            vld_pipe_r <= {vld_pipe_r[RD_LAT-1:0], rd_issue_s};
        end
    end

    // RAM command, frame pulse, sticky error and stall counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_addr_r    <= '0;
            mem_we_r      <= 1'b0;
            mem_wdata_r   <= '0;
            frame_start_r <= 1'b0;
            err_oob_r     <= 1'b0;
            stall_cnt_r   <= 16'h0000;
        end else begin
            frame_start_r <= enable & vs_fall_s & (state_r != ST_OFF);
            if (rd_issue_s) begin
                mem_addr_r <= rd_lin_s;
                mem_we_r   <= 1'b0;
            end else if (wr_acc_s) begin
                mem_addr_r  <= wr_addr;
                mem_wdata_r <= wr_data;
                mem_we_r    <= wr_inb_s;
                if (!wr_inb_s) begin
                    err_oob_r <= 1'b1;
                end
            end else begin
                mem_we_r <= 1'b0;
            end
            if (wr_valid && !wr_ready_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end
        end
    end

    assign wr_ready    = wr_ready_s;
    assign mem_addr    = mem_addr_r;
    assign mem_we      = mem_we_r;
    assign mem_wdata   = mem_wdata_r;
    assign frame_start = frame_start_r;
    assign err_oob     = err_oob_r;
    assign stall_cnt   = stall_cnt_r;
    // Data is taken straight from the RAM so the latency stays exactly RD_LAT+1.
    assign pix_valid   = vld_pipe_r[RD_LAT];
    assign pix_data    = vld_pipe_r[RD_LAT] ? mem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_tft_fb_arbiter.sv
// Self-checking bench for tft_fb_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level model of the arbitration rules.
module tb_tft_fb_arbiter;

    localparam int RD_LAT = 2;
    localparam int TOTAL  = 800 * 480;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        vs;
    logic        pix_req;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        wr_valid;
    logic        wr_ready;
    logic [18:0] wr_addr;
    logic [23:0] wr_data;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [23:0] mem_wdata;
    logic [23:0] mem_rdata;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        frame_start;
    logic        err_oob;
    logic [15:0] stall_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    tft_fb_arbiter #(.RD_LAT(RD_LAT)) dut (
        .clock(clock), .reset(reset), .enable(enable), .vs(vs),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pix_valid(pix_valid), .pix_data(pix_data), .frame_start(frame_start),
        .err_oob(err_oob), .stall_cnt(stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM contents are a fixed hash of the address, so every read has a known answer.
    function automatic logic [23:0] ram_word(input logic [18:0] a);
        return (24'(a) * 24'd40503) ^ 24'hC3A5F0;
    endfunction

    logic [18:0] ram_pipe [0:RD_LAT-1];
    always @(posedge clock) begin
        ram_pipe[0] <= mem_addr;
        for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
    assign mem_rdata = ram_word(ram_pipe[RD_LAT-1]);

    // ---------------- reference model ----------------
    typedef struct { int due; logic [23:0] val; } ret_t;
    ret_t        rq[$];
    int          cyc = 0;
    int          m_mode = 0;      // 0 scan-out off, 1 armed for vsync, 2 scanning
    logic        prev_vs = 1'b1;
    logic [18:0] e_addr = '0;
    logic        e_we = 1'b0;
    logic [23:0] e_wdata = '0;
    logic        e_pv = 1'b0;
    logic [23:0] e_pd = '0;
    logic        e_fs = 1'b0;
    logic        e_err = 1'b0;
    logic [15:0] e_stall = '0;

    wire [86:0] obs_vec = {mem_we, mem_addr, (e_we ? mem_wdata : 24'd0), pix_valid, pix_data,
                           frame_start, err_oob, stall_cnt};
    wire [86:0] exp_vec = {e_we, e_addr, (e_we ? e_wdata : 24'd0), e_pv, e_pd,
                           e_fs, e_err, e_stall};

    function automatic logic model_wr_ready();
        return !((m_mode == 2) && pix_req);
    endfunction

    task automatic model_next();
        logic blocked;
        ret_t r;
        if (reset) begin
            m_mode = 0; prev_vs = 1'b1; e_addr = '0; e_we = 1'b0; e_wdata = '0;
            e_fs = 1'b0; e_err = 1'b0; e_stall = '0; rq.delete();
        end else begin
            blocked = (m_mode == 2) && pix_req;
            if (blocked && pix_x < 10'd800 && pix_y < 9'd480) begin
                e_addr = 19'(int'(pix_y) * 800 + int'(pix_x));
                e_we = 1'b0;
                r.due = cyc + 1 + RD_LAT;
                r.val = ram_word(e_addr);
                rq.push_back(r);
            end else if (wr_valid && !blocked) begin
                e_addr = wr_addr;
                if (int'(wr_addr) < TOTAL) begin
                    e_we = 1'b1; e_wdata = wr_data;
                end else begin
                    e_we = 1'b0; e_err = 1'b1;
                end
            end else begin
                e_we = 1'b0;
            end
            e_fs = enable && (m_mode != 0) && prev_vs && !vs;
            if (wr_valid && blocked && e_stall != 16'hFFFF) e_stall = e_stall + 16'd1;
            if (!enable) m_mode = 0;
            else if (m_mode == 0) m_mode = 1;
            else if (m_mode == 1 && prev_vs && !vs) m_mode = 2;
            prev_vs = vs;
        end
        cyc++;
        e_pv = 1'b0; e_pd = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            e_pv = 1'b1; e_pd = rq[0].val;
            void'(rq.pop_front());
        end
    endtask

    task automatic step();
        model_next();
        @(posedge clock);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; vs = 1'b1; pix_req = 1'b1; pix_x = 10'd3; pix_y = 9'd4;
        wr_valid = 1'b1; wr_addr = 19'd77; wr_data = 24'h123456;
        repeat (3) step();
        tests_run++;
        if (obs_vec !== 87'd0) begin
            tests_failed++; $display("FAIL reset_outputs: got %h want 0", obs_vec);
        end
        tests_run++;
        if (wr_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready);
        end
        reset = 1'b0; wr_valid = 1'b0; pix_req = 1'b0;
        step();
    endtask

    task automatic test_sync();
        for (int i = 0; i < 6; i++) begin
            pix_req = 1'b1; pix_x = 10'($urandom_range(0, 799)); pix_y = 9'($urandom_range(0, 479));
            step();
            tests_run++;
            if (mem_we !== 1'b0 || mem_addr !== 19'd0 || pix_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL sync_no_read: we=%b addr=%0d pv=%b want 0/0/0", mem_we, mem_addr, pix_valid);
            end
        end
        vs = 1'b0;
        step();
        tests_run++;
        if (frame_start !== 1'b1) begin
            tests_failed++; $display("FAIL sync_frame_start: got %b want 1", frame_start);
        end
        vs = 1'b1; pix_x = 10'd17; pix_y = 9'd3;
        step();
        tests_run++;
        if (frame_start !== 1'b0 || mem_addr !== 19'd2417) begin
            tests_failed++;
            $display("FAIL sync_first_read: fs=%b addr=%0d want 0/2417", frame_start, mem_addr);
        end
        pix_req = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_latency();
        int nvalid, first, last;
        pix_req = 1'b1; pix_x = 10'd5; pix_y = 9'd2;
        step();
        tests_run++;
        if (mem_addr !== 19'd1605 || mem_we !== 1'b0) begin
            tests_failed++; $display("FAIL lat_addr: addr=%0d we=%b want 1605/0", mem_addr, mem_we);
        end
        pix_req = 1'b0;
        step();
        tests_run++;
        if (pix_valid !== 1'b0) begin
            tests_failed++; $display("FAIL lat_early: pix_valid=%b want 0", pix_valid);
        end
        step();
        tests_run++;
        if (pix_valid !== 1'b1 || pix_data !== ram_word(19'd1605)) begin
            tests_failed++;
            $display("FAIL lat_data: pv=%b data=%h want 1/%h", pix_valid, pix_data, ram_word(19'd1605));
        end
        step();
        nvalid = 0; first = -1; last = -1;
        for (int i = 0; i < 806; i++) begin
            pix_req = (i < 800); pix_x = 10'(i < 800 ? i : 0); pix_y = 9'd10;
            step();
            if (pix_valid === 1'b1) begin
                nvalid++; if (first < 0) first = i; last = i;
            end
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++; $display("FAIL line_stream: got %h want %h", obs_vec, exp_vec);
            end
        end
        tests_run++;
        if (nvalid != 800 || (last - first) != 799) begin
            tests_failed++;
            $display("FAIL line_gapless: valids=%0d span=%0d want 800/799", nvalid, last - first + 1);
        end
    endtask

    task automatic test_contention();
        logic [18:0] wa;
        logic [23:0] wd;
        logic [15:0] base;
        int low;
        wa = 19'($urandom_range(0, TOTAL - 1)); wd = 24'($urandom);
        base = e_stall; low = 0;
        wr_valid = 1'b1; wr_addr = wa; wr_data = wd;
        for (int i = 0; i < 800; i++) begin
            pix_req = 1'b1; pix_x = 10'(i); pix_y = 9'd11;
            #1;
            if (wr_ready === 1'b0) low++;
            step();
        end
        tests_run++;
        if (low != 800) begin
            tests_failed++; $display("FAIL cont_ready_low: got %0d cycles want 800", low);
        end
        pix_req = 1'b0;
        #1;
        tests_run++;
        if (wr_ready !== 1'b1) begin
            tests_failed++; $display("FAIL cont_blank_ready: got %b want 1", wr_ready);
        end
        step();
        tests_run++;
        if (mem_we !== 1'b1 || mem_addr !== wa || mem_wdata !== wd || stall_cnt !== base + 16'd800) begin
            tests_failed++;
            $display("FAIL cont_write: we=%b addr=%0d data=%h stall=%0d want 1/%0d/%h/%0d",
                     mem_we, mem_addr, mem_wdata, stall_cnt, wa, wd, base + 16'd800);
        end
        wr_valid = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_bounds();
        tests_run++;
        if (err_oob !== 1'b0) begin
            tests_failed++; $display("FAIL bounds_pre: err_oob=%b want 0", err_oob);
        end
        pix_req = 1'b0; wr_valid = 1'b1; wr_addr = 19'd384000; wr_data = 24'hABCDEF;
        step();
        tests_run++;
        if (mem_we !== 1'b0 || err_oob !== 1'b1) begin
            tests_failed++; $display("FAIL bounds_drop: we=%b err=%b want 0/1", mem_we, err_oob);
        end
        wr_valid = 1'b0;
        repeat (3) step();
        tests_run++;
        if (err_oob !== 1'b1) begin
            tests_failed++; $display("FAIL bounds_sticky: err=%b want 1", err_oob);
        end
        wr_valid = 1'b1; wr_addr = 19'd383999;
        step();
        tests_run++;
        if (mem_we !== 1'b1 || mem_addr !== 19'd383999 || err_oob !== 1'b1) begin
            tests_failed++;
            $display("FAIL bounds_last: we=%b addr=%0d err=%b want 1/383999/1", mem_we, mem_addr, err_oob);
        end
        wr_valid = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_abort();
        int nvalid;
        nvalid = 0;
        for (int x = 0; x < 400; x++) begin
            if (x == 200) enable = 1'b0;
            pix_req = 1'b1; pix_x = 10'(x); pix_y = 9'd20;
            wr_valid = 1'b1; wr_addr = 19'($urandom_range(0, TOTAL - 1)); wr_data = 24'($urandom);
            #1;
            if (x > 200) begin
                tests_run++;
                if (wr_ready !== 1'b1) begin
                    tests_failed++; $display("FAIL abort_ready x=%0d: got %b want 1", x, wr_ready);
                end
            end
            step();
            if (pix_valid === 1'b1) nvalid++;
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++; $display("FAIL abort_vec x=%0d: got %h want %h", x, obs_vec, exp_vec);
            end
        end
        pix_req = 1'b0; wr_valid = 1'b0;
        repeat (5) begin
            step();
            if (pix_valid === 1'b1) nvalid++;
        end
        tests_run++;
        if (nvalid != 201) begin
            tests_failed++; $display("FAIL abort_drain: got %0d pixels want 201", nvalid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 599) == 0);
            enable   = ($urandom_range(0, 149) != 0);
            vs       = !((i % 400) == 7);
            pix_req  = ($urandom_range(0, 9) < 7);
            pix_x    = 10'($urandom_range(0, 819));
            pix_y    = ($urandom_range(0, 15) == 0) ? 9'($urandom_range(480, 511))
                                                     : 9'($urandom_range(0, 479));
            wr_valid = $urandom_range(0, 1);
            wr_addr  = ($urandom_range(0, 31) == 0) ? 19'($urandom_range(TOTAL, 524287))
                                                     : 19'($urandom_range(0, TOTAL - 1));
            wr_data  = 24'($urandom);
            #1;
            tests_run++;
            if (wr_ready !== model_wr_ready()) begin
                tests_failed++;
                $display("FAIL rand_ready cyc=%0d: got %b want %b", cyc, wr_ready, model_wr_ready());
            end
            step();
            tests_run++;
            if (obs_vec !== exp_vec) begin
                tests_failed++; $display("FAIL rand_vec cyc=%0d: got %h want %h", cyc, obs_vec, exp_vec);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sync();
        test_latency();
        test_contention();
        test_bounds();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
